// File: rtl/pipe_stall_ctrl_if.sv
// Pipeline hazard bus between the five stages and the stall/flush scheduler.
// The stages drive their hazard requests and read back the stall vector,
// flush/redirect and divider status. The scheduler reads requests and
// drives the results.
interface pipe_stall_ctrl_if #(
    parameter int CNT_W = 32
);
    // Requests from the pipeline stages
    logic             inst_sram_wait;
    logic             data_sram_wait;
    logic             ex_is_load;
    logic [4:0]       ex_rf_waddr;
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             id_use_rs;
    logic             id_use_rt;
    logic             div_start;
    logic             excp_req;
    logic [31:0]      excp_pc;

    // Results back to the pipeline stages
    logic [5:0]       stall;
    logic             flush;
    logic [31:0]      new_pc;
    logic             div_busy;
    logic             div_done;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] lu_cnt;

    // Pipeline side: raises requests, obeys stall/flush
    modport master (
        output inst_sram_wait, data_sram_wait, ex_is_load, ex_rf_waddr,
               id_rs, id_rt, id_use_rs, id_use_rt, div_start, excp_req, excp_pc,
        input  stall, flush, new_pc, div_busy, div_done, stall_cnt, lu_cnt
    );

    // Scheduler side
    modport slave (
        input  inst_sram_wait, data_sram_wait, ex_is_load, ex_rf_waddr,
               id_rs, id_rt, id_use_rs, id_use_rt, div_start, excp_req, excp_pc,
        output stall, flush, new_pc, div_busy, div_done, stall_cnt, lu_cnt
    );
endinterface

// File: rtl/pipe_stall_ctrl.sv
// Central stall/flush scheduler for the 5-stage MIPS pipeline.
// stall[k]=1 freezes stage register k (bit0 PC .. bit5 WB); a 1 followed by
// a 0 at bit k+1 pushes a bubble into stage k+1. Requests are resolved by a
// fixed priority: flush > data wait > divider > load-use > fetch wait.
// A small FSM sequences the multi-cycle divider, and two wrap-around
// counters record stall cycles and load-use bubbles.
module pipe_stall_ctrl #(
    parameter int DIV_CYCLES = 32,   // 2..63
    parameter int CNT_W      = 32
) (
    input  logic               clk,
    input  logic               rst,
    pipe_stall_ctrl_if.slave   bus
);

    localparam logic [5:0] STALL_NONE     = 6'b000000;
    localparam logic [5:0] STALL_IF_WAIT  = 6'b000011;
    localparam logic [5:0] STALL_LOADUSE  = 6'b000111;
    localparam logic [5:0] STALL_DIV      = 6'b001111;
    localparam logic [5:0] STALL_MEM_WAIT = 6'b011111;

    localparam logic [5:0] DIV_LOAD = 6'(DIV_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } div_state_t;

    div_state_t       r_state;
    div_state_t       w_next_state;
    logic [5:0]       r_div_cnt;
    logic [5:0]       w_next_div_cnt;

    logic             r_excp_pend;
    logic [31:0]      r_excp_pc;
    logic [31:0]      r_new_pc;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_lu_cnt;

    logic             w_load_use;
    logic             w_flush;
    logic [31:0]      w_redirect_pc;
    logic [5:0]       w_stall;
    logic             w_sel_lu;

    // Hazard detection and flush decision; combinational outputs are held
    // quiet while rst is high so reset silences them immediately.
    // NOTE: every signal assigned in always_comb gets a default first; a path
    // that leaves one unassigned would infer a latch.
    always_comb begin
        w_load_use    = 1'b0;
        w_flush       = 1'b0;
        w_redirect_pc = bus.excp_pc;
        if (bus.ex_is_load && (bus.ex_rf_waddr != 5'd0)) begin
            w_load_use = (bus.id_use_rs && (bus.id_rs == bus.ex_rf_waddr)) ||
                         (bus.id_use_rt && (bus.id_rt == bus.ex_rf_waddr));
        end
        // A pending exception beats a fresh request: first one wins.
        if (r_excp_pend) begin
            w_redirect_pc = r_excp_pc;
        end
        w_flush = !rst && !bus.data_sram_wait && (r_excp_pend || bus.excp_req);
    end

    // Priority encoder selecting the stall vector for this cycle
    always_comb begin
        w_stall  = STALL_NONE;
        w_sel_lu = 1'b0;
        if (rst || w_flush) begin
            w_stall = STALL_NONE;
        end else if (bus.data_sram_wait) begin
            w_stall = STALL_MEM_WAIT;
        end else if (r_state == S_BUSY) begin
            w_stall = STALL_DIV;
        end else if (w_load_use) begin
            w_stall  = STALL_LOADUSE;
            w_sel_lu = 1'b1;
        end else if (bus.inst_sram_wait) begin
            w_stall = STALL_IF_WAIT;
        end
    end

    // Divider FSM next-state: BUSY lasts DIV_CYCLES cycles, DONE one cycle
    always_comb begin
        w_next_state   = r_state;
        w_next_div_cnt = r_div_cnt;
        case (r_state)
            S_IDLE: begin
                if (bus.div_start && !w_flush) begin
                    w_next_state   = S_BUSY;
                    w_next_div_cnt = DIV_LOAD;
                end
            end
            S_BUSY: begin
                if (w_flush) begin
                    w_next_state = S_IDLE;
                end else if (r_div_cnt == 6'd0) begin
                    w_next_state = S_DONE;
                end else begin
                    w_next_div_cnt = r_div_cnt - 6'd1;
                end
            end
            S_DONE: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Divider FSM state register
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_div_cnt <= '0;
        end else begin
            r_state   <= w_next_state;
            r_div_cnt <= w_next_div_cnt;
        end
    end

    // Exception latch during data wait, and the held redirect PC
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_excp_pend <= 1'b0;
            r_excp_pc   <= '0;
            r_new_pc    <= '0;
        end else begin
            if (w_flush) begin
                r_excp_pend <= 1'b0;
                r_new_pc    <= w_redirect_pc;
            end else if (bus.excp_req && bus.data_sram_wait && !r_excp_pend) begin
                r_excp_pend <= 1'b1;
                r_excp_pc   <= bus.excp_pc;
            end
        end
    end

    // Performance counters; wrap naturally and survive flushes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_lu_cnt    <= '0;
        end else begin
            if (w_stall != STALL_NONE) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if (w_sel_lu) begin
                r_lu_cnt <= r_lu_cnt + 1'b1;
            end
        end
    end

    assign bus.stall     = w_stall;
    assign bus.flush     = w_flush;
    assign bus.new_pc    = w_flush ? w_redirect_pc : r_new_pc;
    assign bus.div_busy  = (r_state == S_BUSY);
    assign bus.div_done  = (r_state == S_DONE);
    assign bus.stall_cnt = r_stall_cnt;
    assign bus.lu_cnt    = r_lu_cnt;

endmodule

// File: doc/pipe_stall_ctrl.md
Name: pipe_stall_ctrl

Overview:
- Central stall/flush scheduler for the 5-stage MIPS pipeline (PC, IF/ID, ID/EX, EX/MEM, MEM/WB, WB).
- Collects requests from IF (instruction SRAM wait), ID (load-use), EX (multi-cycle divider) and MEM (data SRAM wait, exception).
- Produces the `StallBus` vector every stage register consumes, plus flush and redirect PC.
- Sequences the divider through an internal busy counter and keeps stall-cycle performance counters.

Parameters:
- DIV_CYCLES, 32, cycles the divider needs from div_start to result valid (range 2..63).
- CNT_W, 32, width of performance counters.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- inst_sram_wait  in  1  IF fetch not returned this cycle
- data_sram_wait  in  1  MEM data access not returned this cycle
- ex_is_load  in  1  instruction in EX is a load
- ex_rf_waddr  in  5  EX destination register
- id_rs  in  5  ID source register rs
- id_rt  in  5  ID source register rt
- id_use_rs  in  1  ID instruction reads rs
- id_use_rt  in  1  ID instruction reads rt
- div_start  in  1  EX issues a divide (1-cycle pulse)
- excp_req  in  1  MEM reports exception/eret
- excp_pc  in  32  redirect target for excp_req
- stall  out  `StallBus` (6)  bit k=1 stops stage k; bit0 PC ... bit5 WB
- flush  out  1  kill all in-flight stage registers
- new_pc  out  32  redirect PC, valid when flush=1
- div_busy  out  1  divider counting
- div_done  out  1  1-cycle pulse, result valid in EX
- stall_cnt  out  CNT_W  cycles with stall!=0
- lu_cnt  out  CNT_W  load-use bubbles inserted

Behaviour:
- Reset (async): stall=0, flush=0, new_pc=0, div_busy=0, div_done=0, counters=0, FSM=IDLE, excp_pend=0.
- Stall convention: stall[k]=1 & stall[k+1]=0 means stage k+1 receives a bubble.
- Stall encodings: MEM_WAIT=6'b011111; DIV=6'b001111; LOADUSE=6'b000111; IF_WAIT=6'b000011; NONE=0.
- stall is combinational from the current inputs and registered state, so it takes effect in the same cycle.
- Priority, highest first:
  - flush: forces stall=0.
  - data_sram_wait → MEM_WAIT.
  - div_busy → DIV.
  - load-use → LOADUSE.
  - inst_sram_wait → IF_WAIT.
- Load-use condition: ex_is_load & ex_rf_waddr!=0 & ((id_use_rs & id_rs==ex_rf_waddr) | (id_use_rt & id_rt==ex_rf_waddr)).
  - Inserts exactly one bubble.
  - lu_cnt increments on each cycle where LOADUSE is the selected encoding.
- Divider FSM states IDLE, BUSY, DONE:
  - IDLE → BUSY on div_start. cnt loads DIV_CYCLES-1.
  - BUSY: cnt decrements each cycle. On cnt==0 → DONE.
  - DONE: div_done=1 for one cycle, stall released, → IDLE.
  - div_busy=1 only in BUSY, so the stall lasts exactly DIV_CYCLES cycles.
  - div_start outside IDLE is ignored.
  - div_start in the same cycle as a winning flush is ignored.
  - flush while in BUSY → IDLE next cycle; div_done is never pulsed for the cancelled divide.
- Exception/flush:
  - excp_req with data_sram_wait=0: flush=1 and new_pc=excp_pc the same cycle, for exactly one cycle.
  - excp_req with data_sram_wait=1: latch excp_pc and set excp_pend. Stall continues (MEM_WAIT).
  - The first cycle data_sram_wait=0 with excp_pend set issues flush=1 with the latched PC, then clears excp_pend.
  - A further excp_req while excp_pend is set is ignored (first exception wins).
  - new_pc holds its last value when flush=0.
- Counters:
  - stall_cnt increments when stall!=0.
  - Both counters wrap modulo 2^CNT_W and never saturate.
  - Counters are not cleared by flush.
- Reset asserted mid-divide or mid-pending-exception returns everything to reset values immediately. No flush or div_done is emitted.

Test Plan:
- Load-use: EX lw writes $5, ID addu reads rs=$5 with id_use_rs=1 → stall=6'b000111 for exactly 1 cycle, lu_cnt 0→1. Same case with ex_rf_waddr=0 → no stall.
- Divide, DIV_CYCLES=32: div_start at cycle t → stall=6'b001111 for cycles t+1..t+32, div_done=1 at t+33 with stall=0, stall_cnt=32.
- Priority: div BUSY plus data_sram_wait=1 for 3 cycles → stall=6'b011111 for those 3 cycles. Divider count keeps running, and DIV resumes if BUSY remains afterwards.
- Exception during data wait: excp_req with excp_pc=32'hBFC00380 while data_sram_wait=1, wait held 2 more cycles → flush=1, new_pc=32'hBFC00380 in the cycle wait drops. A second excp_req with pc=32'h1234 during the wait is ignored.
- Flush cancels divide: flush at BUSY cycle 10 → div_busy=0 next cycle, no div_done pulse. A new div_start runs the full DIV_CYCLES.
- Async reset mid-BUSY with excp_pend set: rst pulsed between clock edges → all outputs 0 immediately, no flush after release.
